// File: rtl/cic_ctrl_pkg.sv
// Shared types and helpers for the CIC rate controller: state encoding,
// field/counter widths and the rate legality check.
package cic_ctrl_pkg;

  localparam int LOG2R_W      = 3;
  localparam int CLR_CNT_W    = 4;
  localparam int SETTLE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_RUN
  } ctrl_state_e;

  function automatic logic rate_is_legal(input logic [LOG2R_W-1:0] log2r,
                                         input int unsigned max_log2r);
    return (log2r != '0) && (32'(log2r) <= max_log2r);
  endfunction

endpackage

// File: rtl/cic_strobe_watchdog.sv
// Strobe watchdog: reloads on every kick while enabled and pulses expire
// when LIMIT consecutive cycles pass without a kick.
module cic_strobe_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic expire
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (!en || kick) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(LIMIT - 1)) begin
      cnt_d  = '0;
      expire = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cic_rate_ctrl.sv
// Run-time rate controller for the power-of-two CIC decimator: rate handshake,
// CIC clear/settle sequencing and settled-sample forwarding.
// Optional strobe watchdog enabled by defining CIC_RATE_CTRL_WATCHDOG_EN.
module cic_rate_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int N          = 2,
  parameter int LOG2R_MAX  = 7,
  parameter int LOG2R_DEF  = 4,
  parameter int DATA_W     = 14,
  parameter int CLR_CYCLES = 4,
  parameter int SETTLE     = N + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [LOG2R_W-1:0]       cfg_log2r,
  output logic                     cic_rst,
  output logic [LOG2R_W-1:0]       cic_log2r,
  input  logic                     cic_dclk,
  input  logic signed [DATA_W-1:0] cic_data,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     locked,
  output logic                     cfg_err,
  output logic                     timeout
);

  ctrl_state_e              state_q, state_d;
  logic [CLR_CNT_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [SETTLE_CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [LOG2R_W-1:0]       log2r_q, log2r_d;
  logic                     cic_rst_q, cic_rst_d;
  logic                     dclk_q;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     cfg_accept;
  logic                     rate_legal;
  logic                     rate_accept;
  logic                     wd_expire;

  assign cfg_ready   = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign cfg_accept  = cfg_valid && cfg_ready;
  assign rate_legal  = rate_is_legal(cfg_log2r, LOG2R_MAX);
  assign rate_accept = cfg_accept && rate_legal;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    settle_cnt_d = settle_cnt_q;
    log2r_d      = log2r_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    cfg_err_d    = cfg_err_q;

    if (cfg_accept && !rate_legal) begin
      cfg_err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rate_accept) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          log2r_d   = cfg_log2r;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_CNT_W'(CLR_CYCLES - 1)) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cic_dclk) begin
          if (settle_cnt_q == SETTLE_CNT_W'(SETTLE - 1)) begin
            state_d = ST_RUN;
          end else begin
            settle_cnt_d = settle_cnt_q + SETTLE_CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        // A reconfiguration wins over a sample landing in the same cycle.
        if (rate_accept) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          log2r_d   = cfg_log2r;
        end else if (dclk_q) begin
          out_data_d  = cic_data;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wd_expire && !rate_accept) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end
  end

  assign cic_rst_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      settle_cnt_q <= '0;
      log2r_q      <= LOG2R_W'(LOG2R_DEF);
      cic_rst_q    <= 1'b1;
      dclk_q       <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      log2r_q      <= log2r_d;
      cic_rst_q    <= cic_rst_d;
      // Only strobes seen in RUN are captured, so the last settle strobe is never forwarded.
      dclk_q       <= cic_dclk && (state_q == ST_RUN);
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cic_rst   = cic_rst_q;
  assign cic_log2r = log2r_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == ST_RUN);
  assign cfg_err   = cfg_err_q;

`ifdef CIC_RATE_CTRL_WATCHDOG_EN
  logic timeout_q, timeout_d;

  cic_strobe_watchdog #(
    .LIMIT(2 * (2 ** LOG2R_MAX))
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .en    ((state_q == ST_SETTLE) || (state_q == ST_RUN)),
    .kick  (cic_dclk),
    .expire(wd_expire)
  );

  always_comb begin
    timeout_d = timeout_q;
    if (rate_accept) begin
      timeout_d = 1'b0;
    end else if (wd_expire) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed bench for cic_rate_ctrl: a CIC strobe/data model feeds a scoreboard
// of expected samples (value and arrival cycle) checked every cycle.
module tb_cic_rate_ctrl;

  localparam int DW       = 14;
  localparam int SETTLE_N = 4;
  localparam logic signed [DW-1:0] STEP = 14'sd1237;

  typedef struct {
    logic signed [DW-1:0] data;
    int                   cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [2:0]           cfg_log2r = 3'd0;
  logic                 cic_rst;
  logic [2:0]           cic_log2r;
  logic                 cic_dclk = 1'b0;
  logic signed [DW-1:0] cic_data = '0;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 locked;
  logic                 cfg_err;
  logic                 timeout;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   phase = 0;
  int   strobe_idx = 0;
  int   tb_log2r = 4;
  bit   dclk_en = 1'b1;
  bit   rst_done = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cic_rate_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_log2r(cfg_log2r),
    .cic_rst  (cic_rst),
    .cic_log2r(cic_log2r),
    .cic_dclk (cic_dclk),
    .cic_data (cic_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .locked   (locked),
    .cfg_err  (cfg_err),
    .timeout  (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_outs(input int n, input int budget, input string tag);
    int target;
    int k;
    target = n_out + n;
    k = 0;
    while (n_out < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(n_out >= target), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // CIC model: one strobe every 2^tb_log2r cycles while out of clear; data
  // advances on the edge where the strobe is high.
  always @(negedge clk) begin
    logic signed [DW-1:0] nxt;
    if (cic_dclk) cic_data = cic_data + STEP;
    if (cic_rst !== 1'b0 || !dclk_en) begin
      cic_dclk = 1'b0;
      phase = 0;
      if (cic_rst !== 1'b0) strobe_idx = 0;
    end else begin
      phase++;
      if (phase >= (1 << tb_log2r)) begin
        phase = 0;
        cic_dclk = 1'b1;
        strobe_idx++;
        if (strobe_idx > SETTLE_N) begin
          nxt = cic_data + STEP;
          exp_q.push_back('{data: nxt, cyc: cyc + 2});
        end
      end else begin
        cic_dclk = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   due;
    if (rst_done) begin
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("out_valid", 32'(out_valid), 32'(due));
      if (due) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
      end
      if (out_valid === 1'b1) begin
        n_out++;
        $display("sample %0d cyc=%0d log2r=%0d data=%0d", n_out, cyc, cic_log2r, out_data);
      end
    end
  end

  initial begin
    int k;
    int eight;
    eight = 8;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cic_rst", 32'(cic_rst), 32'd1);
    chk("rst_cic_log2r", 32'(cic_log2r), 32'd4);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    rst_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_cic_rst", 32'(cic_rst), 32'd1);
      chk("idle_cic_log2r", 32'(cic_log2r), 32'd4);
      chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("idle_locked", 32'(locked), 32'd0);
    end

    // Legal request R=16 from IDLE.
    cfg_valid = 1'b1;
    cfg_log2r = 3'd4;
    tb_log2r  = 4;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("clear_cfg_ready", 32'(cfg_ready), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(negedge clk);
      chk("clear_cic_rst", 32'(cic_rst), 32'(i <= 4));
    end
    wait_outs(1, 200, "first_sample");
    wait_outs(3, 100, "cadence_r16");
    chk("run_locked", 32'(locked), 32'd1);

    // Illegal requests in RUN.
    @(negedge clk);
    chk("run_cfg_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_log2r = 3'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("illegal0_cfg_err", 32'(cfg_err), 32'd1);
    chk("illegal0_locked", 32'(locked), 32'd1);
    chk("illegal0_cic_log2r", 32'(cic_log2r), 32'd4);
    wait_outs(2, 80, "cadence_after_illegal");
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_log2r = eight[2:0];
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("illegal8_cfg_err", 32'(cfg_err), 32'd1);
    chk("illegal8_cic_log2r", 32'(cic_log2r), 32'd4);
    chk("illegal8_locked", 32'(locked), 32'd1);
    wait_outs(1, 40, "cadence_after_illegal8");

    // Reconfigure 4 -> 6 with the accept in the registered-strobe cycle.
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (cic_dclk !== 1'b1 && k < 100);
    chk("collision_strobe_seen", 32'(cic_dclk), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_log2r = 3'd6;
    tb_log2r  = 6;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("collision_out_valid", 32'(out_valid), 32'd0);
    chk("collision_locked", 32'(locked), 32'd0);
    chk("collision_cic_rst", 32'(cic_rst), 32'd1);
    chk("collision_cic_log2r", 32'(cic_log2r), 32'd6);
    wait_outs(3, 64 * 9 + 20, "resume_r64");
    chk("resume_locked", 32'(locked), 32'd1);

    // Stop the strobes in RUN.
    dclk_en = 1'b0;
`ifdef CIC_RATE_CTRL_WATCHDOG_EN
    k = 0;
    while (timeout !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_cic_rst", 32'(cic_rst), 32'd1);
    chk("wd_locked", 32'(locked), 32'd0);
    dclk_en = 1'b1;
    wait_outs(2, 64 * 8 + 20, "wd_recover");
    chk("wd_timeout_sticky", 32'(timeout), 32'd1);
`else
    repeat (300) @(negedge clk);
    chk("nowd_timeout", 32'(timeout), 32'd0);
    chk("nowd_locked", 32'(locked), 32'd1);
    chk("nowd_cic_rst", 32'(cic_rst), 32'd0);
    dclk_en = 1'b1;
    wait_outs(2, 64 * 3 + 20, "nowd_resume");
`endif

    // Reset while settling.
    cfg_valid = 1'b1;
    cfg_log2r = 3'd5;
    tb_log2r  = 5;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("req5_cic_log2r", 32'(cic_log2r), 32'd5);
    chk("req5_timeout", 32'(timeout), 32'd0);
    k = 0;
    while (cic_rst !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("settle_cic_rst", 32'(cic_rst), 32'd0);
    repeat (3) @(negedge clk);
    chk("settle_locked", 32'(locked), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("midrst_cic_rst", 32'(cic_rst), 32'd1);
    chk("midrst_cic_log2r", 32'(cic_log2r), 32'd4);
    chk("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_cfg_err", 32'(cfg_err), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tb_log2r = 4;
    repeat (3) @(negedge clk);
    chk("post_rst_cic_rst", 32'(cic_rst), 32'd1);
    chk("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("post_rst_locked", 32'(locked), 32'd0);
    chk("post_rst_cic_log2r", 32'(cic_log2r), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
